// File: rtl/bridge_cmd_rx.sv
// bridge_cmd_rx: decodes 8-byte command packets from a byte stream and forwards program payloads
module bridge_cmd_rx #(
  parameter logic [7:0] HEADER = 8'h5A,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_bcmd,
  output logic [4:0]  cmd_lcode,
  output logic [8:0]  cmd_flen,
  output logic [7:0]  cmd_fcmd,
  output logic [31:0] cmd_arg,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  input  logic        pl_ready,
  output logic        pl_last,
  output logic        pl_abort,
  output logic        err_hdr,
  output logic        err_chk,
  output logic        err_bcmd,
  output logic        err_len,
  output logic        err_tmo,
  output logic        pl_chk_err
);
  localparam logic [2:0] IDLE = 3'd0, HDR = 3'd1, CHECK = 3'd2, CMD_OUT = 3'd3, PAYLOAD = 3'd4, PL_CHK = 3'd5;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [2:0]    state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    x_q, x_d, b1_q, b1_d, fcmd_q, fcmd_d;
  logic [31:0]   arg_q, arg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [5:0]    err_q, err_d;
  logic          abort_q, abort_d, run_q;
  logic          acc, tmo_st, bcmd_bad, lcode_bad;

  // run_q keeps in_ready low until the first edge after reset release
  assign in_ready = run_q & ((state_q == IDLE) | (state_q == HDR) | (state_q == PL_CHK) |
                             ((state_q == PAYLOAD) & pl_ready));
  assign acc = in_valid & in_ready;
  assign cmd_bcmd = b1_q[2:0];
  assign cmd_lcode = b1_q[7:3];
  assign cmd_flen = (cmd_lcode == 5'd6) ? 9'd21 : (cmd_lcode == 5'd31) ? 9'd256 : {4'd0, cmd_lcode};
  assign cmd_fcmd = fcmd_q;
  assign cmd_arg = arg_q;
  assign cmd_valid = state_q == CMD_OUT;
  assign pl_data = in_data;
  assign pl_valid = (state_q == PAYLOAD) & in_valid;
  assign pl_last = (state_q == PAYLOAD) & (cnt_q == cmd_flen - 9'd1);
  assign pl_abort = abort_q;
  assign {err_hdr, err_chk, err_bcmd, err_len, err_tmo, pl_chk_err} = err_q;
  assign bcmd_bad = (cmd_bcmd == 3'd0) | (cmd_bcmd >= 3'd6);
  assign lcode_bad = !(((cmd_lcode >= 5'd1) && (cmd_lcode <= 5'd6)) || (cmd_lcode == 5'd31));
  assign tmo_st = (state_q == HDR) | (state_q == PAYLOAD) | (state_q == PL_CHK);

  // packet FSM; x_q holds the header XOR (must end at zero) and later the payload XOR
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    x_d = x_q;
    b1_d = b1_q;
    fcmd_d = fcmd_q;
    arg_d = arg_q;
    tmo_d = tmo_q;
    err_d = '0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        if (in_data == HEADER) begin
          state_d = HDR;
          cnt_d = '0;
          x_d = '0;
        end else err_d[5] = 1'b1;
      end
      HDR: if (acc) begin
        x_d = x_q ^ in_data;
        cnt_d = cnt_q + 9'd1;
        if (cnt_q[2:0] == 3'd0) b1_d = in_data;
        if (cnt_q[2:0] == 3'd1) fcmd_d = in_data;
        if (cnt_q[2:0] >= 3'd2 && cnt_q[2:0] <= 3'd5) arg_d = {arg_q[23:0], in_data};
        if (cnt_q[2:0] == 3'd6) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        if (x_q != 8'd0) err_d[4] = 1'b1;
        else if (bcmd_bad) err_d[3] = 1'b1;
        else if (lcode_bad) err_d[2] = 1'b1;
        else state_d = CMD_OUT;
      end
      CMD_OUT: if (cmd_ready) begin
        state_d = (cmd_bcmd == 3'd3) ? PAYLOAD : IDLE;
        cnt_d = '0;
        x_d = '0;
      end
      PAYLOAD: if (acc) begin
        x_d = x_q ^ in_data;
        cnt_d = cnt_q + 9'd1;
        if (pl_last) state_d = PL_CHK;
      end
      PL_CHK: if (acc) begin
        err_d[0] = in_data != x_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tmo_st) begin
      if (acc) tmo_d = '0;
      else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        tmo_d = '0;
        err_d[1] = 1'b1;
        abort_d = state_q != HDR;
        state_d = IDLE;
      end else tmo_d = tmo_q + TW'(1);
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      x_q <= '0;
      b1_q <= '0;
      fcmd_q <= '0;
      arg_q <= '0;
      tmo_q <= '0;
      err_q <= '0;
      abort_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      b1_q <= b1_d;
      fcmd_q <= fcmd_d;
      arg_q <= arg_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
      abort_q <= abort_d;
      run_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bridge_cmd_rx.sv
// tb_bridge_cmd_rx: directed scoreboard bench for bridge_cmd_rx
module tb_bridge_cmd_rx;
  logic clk = 0, rst_n = 0;
  logic [7:0] in_data = 0;
  logic in_valid = 0, cmd_ready = 1, pl_ready = 1;
  logic in_ready, cmd_valid, pl_valid, pl_last, pl_abort;
  logic err_hdr, err_chk, err_bcmd, err_len, err_tmo, pl_chk_err;
  logic [2:0] cmd_bcmd;
  logic [4:0] cmd_lcode;
  logic [8:0] cmd_flen;
  logic [7:0] cmd_fcmd, pl_data;
  logic [31:0] cmd_arg;
  int tests = 0, fails = 0;
  int n_hdr = 0, n_chk = 0, n_bcmd = 0, n_len = 0, n_tmo = 0, n_plchk = 0, n_abort = 0;
  logic [56:0] cmd_q[$];
  logic [8:0] pl_q[$];
  bit rnd = 0;

  bridge_cmd_rx dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bcmd(cmd_bcmd), .cmd_lcode(cmd_lcode),
    .cmd_flen(cmd_flen), .cmd_fcmd(cmd_fcmd), .cmd_arg(cmd_arg), .pl_data(pl_data),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_last(pl_last), .pl_abort(pl_abort),
    .err_hdr(err_hdr), .err_chk(err_chk), .err_bcmd(err_bcmd), .err_len(err_len),
    .err_tmo(err_tmo), .pl_chk_err(pl_chk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int errsum();
    return n_hdr + n_chk + n_bcmd + n_len + n_tmo + n_plchk + n_abort;
  endfunction

  // scoreboard: pop expectations on every command and payload handshake, tally error pulses
  always @(negedge clk) if (rst_n) begin
    if (cmd_valid && cmd_ready) begin
      if (cmd_q.size() == 0) chk("cmd_unexpected", 64'(cmd_q.size()), 1);
      else chk("cmd_fields", {cmd_bcmd, cmd_lcode, cmd_flen, cmd_fcmd, cmd_arg}, cmd_q.pop_front());
    end
    if (pl_valid && pl_ready) begin
      if (pl_q.size() == 0) chk("pl_unexpected", 64'(pl_q.size()), 1);
      else chk("pl_beat", {pl_last, pl_data}, pl_q.pop_front());
    end
    n_hdr += int'(err_hdr);
    n_chk += int'(err_chk);
    n_bcmd += int'(err_bcmd);
    n_len += int'(err_len);
    n_tmo += int'(err_tmo);
    n_plchk += int'(pl_chk_err);
    n_abort += int'(pl_abort);
  end

  initial forever begin
    @(posedge clk);
    #1;
    pl_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data = b;
    in_valid = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("send_stall", 64'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic send_pkt(input logic [63:0] p);
    for (int i = 7; i >= 0; i--) send(p[i*8 +: 8]);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tmo(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_tmo && n < 5000);
  endtask

  initial begin
    int e0, p0, lat;
    in_valid = 1;
    in_data = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_outs", {cmd_valid, pl_valid, pl_last, pl_abort, err_hdr, err_chk, err_bcmd, err_len, err_tmo, pl_chk_err}, 0);
    chk("rst_fields", {cmd_bcmd, cmd_lcode, cmd_flen, cmd_fcmd, cmd_arg}, 0);
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 64'(in_ready), 1);
    e0 = errsum();
    cmd_q.push_back({3'd4, 5'd2, 9'd2, 8'h05, 32'h0});
    send_pkt(64'h5A14050000000011);
    wait_cyc(4);
    chk("basic_cmd_done", 64'(cmd_q.size()), 0);
    chk("basic_no_err", 64'(errsum()), 64'(e0));
    for (int k = 0; k < 2; k++) begin
      e0 = errsum();
      p0 = n_plchk;
      rnd = 1;
      cmd_q.push_back({3'd3, 5'd31, 9'd256, 8'h12, 32'h01020304});
      for (int i = 0; i < 256; i++) pl_q.push_back({i == 255, 8'(i)});
      send_pkt(64'h5AFB1201020304ED);
      for (int i = 0; i < 256; i++) send(8'(i));
      send(8'(k));
      rnd = 0;
      wait_cyc(4);
      chk("pl_cmd_done", 64'(cmd_q.size()), 0);
      chk("pl_beats_done", 64'(pl_q.size()), 0);
      chk("pl_chk_err_cnt", 64'(n_plchk - p0), 64'(k));
      chk("pl_other_err", 64'(errsum() - n_plchk), 64'(e0 - p0));
      chk("pl_back_idle", 64'(in_ready), 1);
    end
    e0 = n_hdr;
    p0 = n_chk;
    send(8'h33);
    send_pkt(64'h5A14050000000012);
    wait_cyc(4);
    chk("err_hdr_cnt", 64'(n_hdr - e0), 1);
    chk("err_chk_cnt", 64'(n_chk - p0), 1);
    e0 = n_bcmd;
    p0 = n_len;
    send_pkt(64'h5A1600000000_0016);
    wait_cyc(4);
    chk("err_bcmd_cnt", 64'(n_bcmd - e0), 1);
    send_pkt(64'h5A3C00000000003C);
    wait_cyc(4);
    chk("err_len_cnt", 64'(n_len - p0), 1);
    chk("err_no_cmd", 64'(cmd_q.size()), 0);
    cmd_ready = 0;
    cmd_q.push_back({3'd3, 5'd6, 9'd21, 8'hAA, 32'h11223344});
    send_pkt(64'h5A33AA11223344DD);
    wait_cyc(1);
    for (int i = 0; i < 10; i++) begin
      wait_cyc(1);
      chk("hold_valid", 64'(cmd_valid), 1);
      chk("hold_in_ready", 64'(in_ready), 0);
      chk("hold_fields", {cmd_bcmd, cmd_lcode, cmd_flen, cmd_fcmd, cmd_arg}, {3'd3, 5'd6, 9'd21, 8'hAA, 32'h11223344});
    end
    cmd_ready = 1;
    e0 = n_tmo;
    p0 = n_abort;
    for (int i = 0; i < 3; i++) begin
      pl_q.push_back({1'b0, 8'hA1 + 8'(i)});
      send(8'hA1 + 8'(i));
    end
    wait_tmo(lat);
    chk("pl_tmo_latency", 64'(lat), 4097);
    wait_cyc(2);
    chk("pl_tmo_cnt", 64'(n_tmo - e0), 1);
    chk("pl_abort_cnt", 64'(n_abort - p0), 1);
    chk("pl_tmo_idle", 64'(in_ready), 1);
    chk("pl_tmo_beats", 64'(pl_q.size()), 0);
    e0 = n_tmo;
    p0 = n_abort;
    send(8'h5A);
    send(8'h14);
    wait_tmo(lat);
    chk("hdr_tmo_latency", 64'(lat), 4097);
    wait_cyc(2);
    chk("hdr_tmo_cnt", 64'(n_tmo - e0), 1);
    chk("hdr_no_abort", 64'(n_abort - p0), 0);
    e0 = errsum();
    send(8'h5A);
    send(8'h14);
    send(8'h05);
    rst_n = 0;
    wait_cyc(2);
    chk("mid_rst_in_ready", 64'(in_ready), 0);
    rst_n = 1;
    wait_cyc(2);
    cmd_q.push_back({3'd4, 5'd2, 9'd2, 8'h05, 32'h0});
    send_pkt(64'h5A14050000000011);
    wait_cyc(4);
    chk("mid_rst_cmd_done", 64'(cmd_q.size()), 0);
    chk("mid_rst_no_err", 64'(errsum()), 64'(e0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bridge_cmd_rx.md
BRIDGE_CMD_RX -- requirements
Module: bridge_cmd_rx

Interface
REQ-001 SHALL have parameter HEADER, default 8'h5A, meaning the required first byte of a command packet.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096, meaning the maximum idle cycles between accepted bytes inside a packet.
REQ-003 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have ports in_data (input, 8), in_valid (input, 1) and in_ready (output, 1), meaning the byte stream from the USB CDC receive side.
REQ-006 SHALL have ports cmd_valid (output, 1) and cmd_ready (input, 1), meaning the decoded-command handshake.
REQ-007 SHALL have ports cmd_bcmd (output, 3), cmd_lcode (output, 5), cmd_flen (output, 9), cmd_fcmd (output, 8) and cmd_arg (output, 32), meaning the decoded command fields.
REQ-008 SHALL have ports pl_data (output, 8), pl_valid (output, 1), pl_ready (input, 1), pl_last (output, 1) and pl_abort (output, 1), meaning the payload stream for the program-memory command.
REQ-009 SHALL have ports err_hdr, err_chk, err_bcmd, err_len, err_tmo and pl_chk_err (outputs, 1 each), meaning one-cycle error pulses.

Function
REQ-010 SHALL accept a byte only on a cycle where in_valid and in_ready are both 1; when in_valid=1 and in_ready=0, in_data SHALL NOT be consumed.
REQ-011 SHALL use the 8-byte packet format: b0 header, b1 = {lcode[7:3], bcmd[2:0]}, b2 fcmd, b3..b6 arg (MSB first), b7 check = XOR of b1..b6.
REQ-012 SHALL implement the states IDLE, HDR, CHECK, CMD_OUT, PAYLOAD and PL_CHK.
REQ-013 In IDLE, SHALL hold in_ready=1; an accepted byte equal to HEADER moves to HDR; any other accepted byte is dropped, pulses err_hdr and stays in IDLE.
REQ-014 In HDR, SHALL hold in_ready=1, collect b1..b7 using a byte counter, and move to CHECK after b7 is accepted.
REQ-015 In CHECK (one cycle, in_ready=0), SHALL apply the first matching check and, on any error, pulse the error and return to IDLE with no cmd_valid:
- checksum mismatch pulses err_chk;
- bcmd in {0,6,7} pulses err_bcmd;
- lcode not in {1..6, 0x1F} pulses err_len.
REQ-016 If CHECK finds no error, SHALL move to CMD_OUT.
REQ-017 SHALL decode cmd_flen as: lcode 1..5 gives 1..5; lcode 6 gives 21; lcode 0x1F gives 256.
REQ-018 In CMD_OUT, SHALL assert cmd_valid with all fields stable and in_ready=0 until cmd_ready=1; the handshake cycle leaves to PAYLOAD if bcmd=3, otherwise to IDLE.
REQ-019 In PAYLOAD, SHALL drive in_ready = pl_ready, pl_valid = in_valid and pl_data = in_data combinationally (zero latency), and forward exactly cmd_flen bytes.
REQ-020 In PAYLOAD, SHALL assert pl_last with the final byte, and move to PL_CHK when that byte is accepted.
REQ-021 In PL_CHK, SHALL hold in_ready=1 and accept one byte; if it differs from the running XOR of the payload, SHALL pulse pl_chk_err; then SHALL return to IDLE.
REQ-022 In HDR, PAYLOAD and PL_CHK, a timeout counter SHALL clear on every accepted byte; on reaching TIMEOUT_CYC it SHALL pulse err_tmo and return to IDLE.
REQ-023 A timeout in PAYLOAD or PL_CHK SHALL also pulse pl_abort.
REQ-024 The timeout counter SHALL be frozen in IDLE and CMD_OUT.
REQ-025 A HEADER-valued byte received inside HDR or PAYLOAD SHALL be treated as data (no resynchronisation).
REQ-026 pl_valid SHALL be 0 outside PAYLOAD.
REQ-027 cmd_valid SHALL be 0 outside CMD_OUT.

Reset
REQ-028 While rst_n=0, SHALL force the state to IDLE and clear all counters and the payload XOR.
REQ-029 While rst_n=0, SHALL drive in_ready=0, cmd_valid=0, all cmd_* fields=0, pl_valid=0, pl_last=0, pl_abort=0 and all error pulses=0.
REQ-030 After release, in_ready SHALL rise on the first clk edge.
REQ-031 A reset mid-packet SHALL discard the partial packet without error pulses.

Verification
REQ-032 Stream 5A 14 05 00 00 00 00 11 -> cmd_valid with bcmd=4, lcode=2, flen=2, fcmd=0x05, arg=0; no errors.
REQ-033 Stream 5A FB 12 01 02 03 04 ED, then 256 bytes 0x00..0xFF, then 0x00 -> cmd bcmd=3, flen=256, arg=0x01020304; 256 pl beats with pl_last on 0xFF; no pl_chk_err.
REQ-034 Same as REQ-033 but with final byte 0x01 -> pl_chk_err pulses once, and the state returns to IDLE.
REQ-035 Stream 33, then 5A 14 05 00 00 00 00 12 -> err_hdr pulses for 0x33, err_chk pulses once, and no cmd_valid.
REQ-036 Stream 5A 16 00 00 00 00 00 16 -> err_bcmd pulses; stream 5A 3C 00 00 00 00 00 3C (lcode 7) -> err_len pulses.
REQ-037 Hold cmd_ready=0 for 10 cycles in CMD_OUT -> fields stable and in_ready=0; stop bytes after 3 payload bytes -> err_tmo and pl_abort pulse after 4096 cycles.
